// File: rtl/trig_delay_sequencer_if.sv
// Configuration, trigger and status bundle for the trigger delay sequencer.
// The bench/host side uses the master modport; the sequencer uses the slave modport.
interface trig_delay_sequencer_if #(
    parameter int unsigned CNT_W = 16
);
    localparam int unsigned TRIG_CNT_W = 16;
    localparam int unsigned OVR_CNT_W  = 8;

    logic                  trig_async;
    logic                  enable;
    logic [CNT_W-1:0]      delay_cycles;
    logic [CNT_W-1:0]      width_cycles;
    logic [CNT_W-1:0]      timeout_cycles;
    logic                  clear;
    logic                  pulse_out;
    logic                  busy;
    logic                  timeout_flag;
    logic [TRIG_CNT_W-1:0] trig_count;
    logic [OVR_CNT_W-1:0]  overrun_cnt;

    modport master (
        output trig_async, enable, delay_cycles, width_cycles, timeout_cycles, clear,
        input  pulse_out, busy, timeout_flag, trig_count, overrun_cnt
    );

    modport slave (
        input  trig_async, enable, delay_cycles, width_cycles, timeout_cycles, clear,
        output pulse_out, busy, timeout_flag, trig_count, overrun_cnt
    );
endinterface

// File: rtl/trig_delay_sequencer.sv
// Synchronises an asynchronous trigger, waits a programmable delay, then emits a
// programmable-width pulse; also tracks accepted/overrun triggers and a missing-trigger watchdog.
module trig_delay_sequencer #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2   // must be >= 2
) (
    input  logic                 clk,
    input  logic                 rst,
    trig_delay_sequencer_if.slave bus
);

    localparam int unsigned TRIG_CNT_W = 16;
    localparam int unsigned OVR_CNT_W  = 8;
    localparam logic [OVR_CNT_W-1:0] OVR_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DELAY = 2'd2,
        PULSE = 2'd3
    } state_e;

    // Last index of a pulse of the given width; a width of zero behaves as one.
    function automatic logic [CNT_W-1:0] pulse_last(input logic [CNT_W-1:0] w);
        return (w == '0) ? '0 : w - CNT_W'(1);
    endfunction

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise_q;

    state_e                 state_q,     state_d;
    logic [CNT_W-1:0]       seq_cnt_q,   seq_cnt_d;
    logic [CNT_W-1:0]       width_lat_q, width_lat_d;
    logic [CNT_W-1:0]       wd_cnt_q,    wd_cnt_d;
    logic                   flag_q,      flag_d;
    logic [TRIG_CNT_W-1:0]  trig_cnt_q,  trig_cnt_d;
    logic [OVR_CNT_W-1:0]   ovr_cnt_q,   ovr_cnt_d;
    logic                   pulse_q,     pulse_d;
    logic                   busy_q,      busy_d;

    logic [CNT_W-1:0]       wd_inc;
    logic                   seq_active;

    assign wd_inc     = wd_cnt_q + CNT_W'(1);
    assign seq_active = (state_q == DELAY) || (state_q == PULSE);

    // Synchroniser chain, previous-value register and registered rise strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.trig_async};
            prev_q <= sync_q[SYNC_STAGES-1];
            rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

    // Next-state, counter and status logic.
    always_comb begin
        state_d     = state_q;
        seq_cnt_d   = seq_cnt_q;
        width_lat_d = width_lat_q;
        wd_cnt_d    = '0;
        flag_d      = flag_q;
        trig_cnt_d  = trig_cnt_q;
        ovr_cnt_d   = ovr_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (bus.enable) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (!bus.enable) begin
                    state_d = IDLE;
                end else if (rise_q) begin
                    trig_cnt_d  = trig_cnt_q + TRIG_CNT_W'(1);
                    width_lat_d = bus.width_cycles;
                    if (bus.delay_cycles == '0) begin
                        state_d   = PULSE;
                        seq_cnt_d = pulse_last(bus.width_cycles);
                    end else begin
                        state_d   = DELAY;
                        seq_cnt_d = bus.delay_cycles - CNT_W'(1);
                    end
                end else if (bus.timeout_cycles != '0) begin
                    // Watchdog counts up once, fires on reaching the period, then holds.
                    if (wd_cnt_q < bus.timeout_cycles) begin
                        wd_cnt_d = wd_inc;
                        if (wd_inc == bus.timeout_cycles) begin
                            flag_d = 1'b1;
                        end
                    end else begin
                        wd_cnt_d = wd_cnt_q;
                    end
                end
            end
            DELAY: begin
                if (seq_cnt_q == '0) begin
                    state_d   = PULSE;
                    seq_cnt_d = pulse_last(width_lat_q);
                end else begin
                    seq_cnt_d = seq_cnt_q - CNT_W'(1);
                end
            end
            PULSE: begin
                if (seq_cnt_q == '0) begin
                    state_d = bus.enable ? ARMED : IDLE;
                end else begin
                    seq_cnt_d = seq_cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Triggers during an active sequence are only counted, saturating.
        if (seq_active && rise_q && (ovr_cnt_q != OVR_MAX)) begin
            ovr_cnt_d = ovr_cnt_q + OVR_CNT_W'(1);
        end

        if (bus.clear) begin
            ovr_cnt_d = '0;
            flag_d    = 1'b0;
        end

        pulse_d = (state_d == PULSE);
        busy_d  = (state_d == DELAY) || (state_d == PULSE);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            seq_cnt_q   <= '0;
            width_lat_q <= '0;
            wd_cnt_q    <= '0;
            flag_q      <= 1'b0;
            trig_cnt_q  <= '0;
            ovr_cnt_q   <= '0;
            pulse_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            seq_cnt_q   <= seq_cnt_d;
            width_lat_q <= width_lat_d;
            wd_cnt_q    <= wd_cnt_d;
            flag_q      <= flag_d;
            trig_cnt_q  <= trig_cnt_d;
            ovr_cnt_q   <= ovr_cnt_d;
            pulse_q     <= pulse_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.pulse_out    = pulse_q;
    assign bus.busy         = busy_q;
    assign bus.timeout_flag = flag_q;
    assign bus.trig_count   = trig_cnt_q;
    assign bus.overrun_cnt  = ovr_cnt_q;

endmodule

// File: tb/tb_trig_delay_sequencer.sv
// Directed bench for trig_delay_sequencer; loop index j means "sampled after edge N+j",
// where edge N is the first clock edge that samples the trigger high.
module tb_trig_delay_sequencer;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    trig_delay_sequencer_if #(.CNT_W(16)) bus ();

    trig_delay_sequencer #(.CNT_W(16), .SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst                = 1'b1;
        bus.trig_async     = 1'b0;
        bus.enable         = 1'b0;
        bus.delay_cycles   = '0;
        bus.width_cycles   = '0;
        bus.timeout_cycles = '0;
        bus.clear          = 1'b0;
        cyc(3);
        check("rst_pulse", bus.pulse_out, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_flag", bus.timeout_flag, 0);
        check("rst_trig_count", bus.trig_count, 0);
        check("rst_overrun", bus.overrun_cnt, 0);

        // D=3, W=4: pulse on edges N+6..N+9
        rst = 1'b0;
        bus.enable       = 1'b1;
        bus.delay_cycles = 16'd3;
        bus.width_cycles = 16'd4;
        cyc(3);
        bus.trig_async = 1'b1;
        for (int j = 0; j <= 10; j++) begin
            cyc(1);
            check("s1_pulse", bus.pulse_out, (j >= 6 && j <= 9));
            check("s1_busy", bus.busy, (j >= 3 && j <= 9));
        end
        check("s1_trig_count", bus.trig_count, 1);
        check("s1_overrun", bus.overrun_cnt, 0);

        // D=0, W=0: single-cycle pulse at N+3
        bus.trig_async   = 1'b0;
        bus.delay_cycles = 16'd0;
        bus.width_cycles = 16'd0;
        cyc(3);
        bus.trig_async = 1'b1;
        for (int j = 0; j <= 5; j++) begin
            cyc(1);
            check("s2_pulse", bus.pulse_out, (j == 3));
            check("s2_busy", bus.busy, (j == 3));
        end
        check("s2_trig_count", bus.trig_count, 2);

        // D=10, W=5: retrigger in DELAY and on the last PULSE cycle are overruns
        bus.trig_async   = 1'b0;
        bus.delay_cycles = 16'd10;
        bus.width_cycles = 16'd5;
        cyc(3);
        bus.trig_async = 1'b1;
        for (int j = 0; j <= 22; j++) begin
            cyc(1);
            check("s3_pulse", bus.pulse_out, (j >= 13 && j <= 17));
            check("s3_busy", bus.busy, (j >= 3 && j <= 17));
            if (j == 2)  bus.trig_async = 1'b0;
            if (j == 5)  bus.trig_async = 1'b1;
            if (j == 8)  bus.trig_async = 1'b0;
            if (j == 14) bus.trig_async = 1'b1;
        end
        check("s3_trig_count", bus.trig_count, 3);
        check("s3_overrun", bus.overrun_cnt, 2);
        bus.trig_async = 1'b0;
        bus.clear      = 1'b1;
        cyc(1);
        bus.clear = 1'b0;
        check("s3_overrun_cleared", bus.overrun_cnt, 0);
        check("s3_trig_count_kept", bus.trig_count, 3);

        // Watchdog: 20 cycles in ARMED with no trigger
        bus.enable = 1'b0;
        cyc(3);
        check("wd_idle_busy", bus.busy, 0);
        bus.timeout_cycles = 16'd20;
        bus.enable         = 1'b1;
        for (int j = 0; j <= 25; j++) begin
            cyc(1);
            if (j == 19) check("wd_flag_before", bus.timeout_flag, 0);
            if (j == 20) check("wd_flag_set", bus.timeout_flag, 1);
            if (j == 25) check("wd_flag_held", bus.timeout_flag, 1);
        end
        bus.delay_cycles = 16'd0;
        bus.width_cycles = 16'd0;
        bus.trig_async   = 1'b1;
        for (int j = 0; j <= 5; j++) begin
            cyc(1);
            check("wd_pulse", bus.pulse_out, (j == 3));
        end
        check("wd_flag_sticky", bus.timeout_flag, 1);
        check("wd_trig_count", bus.trig_count, 4);
        bus.trig_async = 1'b0;
        bus.clear      = 1'b1;
        cyc(1);
        bus.clear          = 1'b0;
        bus.timeout_cycles = 16'd0;
        check("wd_flag_cleared", bus.timeout_flag, 0);

        // Enable dropped in DELAY: sequence completes, then IDLE
        bus.delay_cycles = 16'd4;
        bus.width_cycles = 16'd2;
        cyc(2);
        bus.trig_async = 1'b1;
        for (int j = 0; j <= 12; j++) begin
            cyc(1);
            check("en_pulse", bus.pulse_out, (j >= 7 && j <= 8));
            check("en_busy", bus.busy, (j >= 3 && j <= 8));
            if (j == 2) bus.trig_async = 1'b0;
            if (j == 3) bus.enable = 1'b0;
        end
        check("en_trig_count", bus.trig_count, 5);
        bus.trig_async = 1'b1;
        cyc(5);
        bus.trig_async = 1'b0;
        cyc(5);
        bus.trig_async = 1'b1;
        cyc(5);
        bus.trig_async = 1'b0;
        cyc(3);
        check("idle_trig_count", bus.trig_count, 5);
        check("idle_overrun", bus.overrun_cnt, 0);
        check("idle_busy", bus.busy, 0);

        // Reset mid-PULSE with trigger held high; one new sequence afterwards
        bus.enable       = 1'b1;
        bus.delay_cycles = 16'd2;
        bus.width_cycles = 16'd10;
        cyc(3);
        bus.trig_async = 1'b1;
        for (int j = 0; j <= 26; j++) begin
            cyc(1);
            check("rs_pulse", bus.pulse_out, ((j >= 5 && j <= 7) || (j >= 14 && j <= 23)));
            check("rs_busy", bus.busy, ((j >= 3 && j <= 7) || (j >= 12 && j <= 23)));
            if (j == 6) check("rs_count_before", bus.trig_count, 6);
            if (j == 7) rst = 1'b1;
            if (j == 8) begin
                check("rs_trig_count_zero", bus.trig_count, 0);
                check("rs_overrun_zero", bus.overrun_cnt, 0);
                check("rs_flag_zero", bus.timeout_flag, 0);
                rst = 1'b0;
            end
        end
        check("rs_trig_count", bus.trig_count, 1);
        check("rs_overrun", bus.overrun_cnt, 0);
        bus.trig_async = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
